// File: rtl/mnist_frame_downsampler.sv
// mnist_frame_downsampler
// Crops a centred window from an RGB565 pixel stream, converts each pixel to
// (optionally inverted) 8-bit luma and box-averages square blocks into an
// OUT_DIM x OUT_DIM byte buffer read through img_idx/img_data.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   pix_valid/data/sof   RGB565 pixel stream; sof marks pixel (0,0)
//   cap_start            single-cycle capture request
//   busy                 capture armed (WAIT_SOF) or running (CAPTURE)
//   frame_ready          buffer holds one complete frame (DONE)
//   frame_count          completed captures, wraps 255 -> 0
//   img_idx / img_data   synchronous read port, 1-cycle latency, 0 beyond buffer
module mnist_frame_downsampler #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned CROP_X0  = 96,
    parameter int unsigned CROP_Y0  = 16,
    parameter int unsigned BLK_LOG2 = 4,
    parameter int unsigned OUT_DIM  = 28,
    parameter int unsigned INVERT   = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    input  logic        cap_start,
    output logic        busy,
    output logic        frame_ready,
    output logic [7:0]  frame_count,
    input  logic [9:0]  img_idx,
    output logic [7:0]  img_data
);

    localparam int unsigned CW    = 11;
    localparam int unsigned BW    = $clog2(OUT_DIM);
    localparam int unsigned IW    = 10;
    localparam int unsigned AW    = 16;
    localparam int unsigned NBLK  = OUT_DIM * OUT_DIM;
    localparam int unsigned EDGE  = OUT_DIM << BLK_LOG2;
    localparam int unsigned SHIFT = 2 * BLK_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   x_q, x_d, y_q, y_d;
    logic [AW-1:0]   acc_q [OUT_DIM];
    logic [AW-1:0]   acc_d [OUT_DIM];
    logic            s1_valid_q, s1_valid_d;
    logic [7:0]      s1_luma_q, s1_luma_d;
    logic [BW-1:0]   s1_bx_q, s1_bx_d, s1_by_q, s1_by_d;
    logic            s1_last_q, s1_last_d;
    logic            busy_q, busy_d;
    logic            frame_ready_q, frame_ready_d;
    logic [7:0]      frame_count_q, frame_count_d;
    logic [7:0]      img_data_q, img_data_d;

    logic [7:0]      mem [NBLK];

    logic            start_frame, pix_take, in_crop, blk_last, done_evt;
    logic [CW-1:0]   cur_x, cur_y, dx, dy;
    logic [7:0]      r8, g8, b8, luma;
    logic [15:0]     luma_sum;
    logic [AW-1:0]   blk_sum;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [7:0]      wr_data;

    // Stage 0: pixel coordinates, crop test and luma conversion.
    always_comb begin : pixel_front
        start_frame = pix_valid && pix_sof && (state_q == WAIT_SOF || state_q == CAPTURE);
        pix_take    = pix_valid && (state_q == CAPTURE || start_frame);
        cur_x       = start_frame ? '0 : x_q;
        cur_y       = start_frame ? '0 : y_q;
        dx          = cur_x - CW'(CROP_X0);
        dy          = cur_y - CW'(CROP_Y0);
        // dx/dy wrap when below the crop origin, so both bounds are tested.
        in_crop     = (cur_x >= CW'(CROP_X0)) && (dx < CW'(EDGE)) &&
                      (cur_y >= CW'(CROP_Y0)) && (dy < CW'(EDGE)) &&
                      (cur_y < CW'(V_ACTIVE));
        blk_last    = (&dx[BLK_LOG2-1:0]) && (&dy[BLK_LOG2-1:0]);

        r8       = {pix_data[15:11], pix_data[15:13]};
        g8       = {pix_data[10:5],  pix_data[10:9]};
        b8       = {pix_data[4:0],   pix_data[4:2]};
        luma_sum = 16'd77 * 16'(r8) + 16'd150 * 16'(g8) + 16'd29 * 16'(b8);
        luma     = (INVERT != 0) ? 8'(8'd255 - luma_sum[15:8]) : luma_sum[15:8];

        // y saturates at V_ACTIVE so trailing lines stay outside the crop.
        x_d = x_q;
        y_d = y_q;
        if (pix_take) begin
            if (cur_x == CW'(H_ACTIVE - 1)) begin
                x_d = '0;
                y_d = (cur_y < CW'(V_ACTIVE)) ? cur_y + CW'(1) : cur_y;
            end else begin
                x_d = cur_x + CW'(1);
                y_d = cur_y;
            end
        end

        s1_valid_d = pix_take && in_crop;
        s1_luma_d  = luma;
        s1_bx_d    = BW'(dx >> BLK_LOG2);
        s1_by_d    = BW'(dy >> BLK_LOG2);
        s1_last_d  = blk_last;
    end

    // Stage 2: column accumulation and block write-back.
    always_comb begin : accumulate
        for (int i = 0; i < int'(OUT_DIM); i++) begin
            acc_d[i] = acc_q[i];
        end
        blk_sum = acc_q[s1_bx_q] + AW'(s1_luma_q);
        wr_en   = 1'b0;
        wr_idx  = IW'(s1_by_q) * IW'(OUT_DIM) + IW'(s1_bx_q);
        wr_data = 8'(blk_sum >> SHIFT);
        if (s1_valid_q && state_q == CAPTURE) begin
            if (s1_last_q) begin
                wr_en            = 1'b1;
                acc_d[s1_bx_q]   = '0;
            end else begin
                acc_d[s1_bx_q]   = blk_sum;
            end
        end
        // A new frame start discards partial sums; buffer writes already done stay.
        if (start_frame) begin
            for (int i = 0; i < int'(OUT_DIM); i++) begin
                acc_d[i] = '0;
            end
        end
    end

    // Capture control and registered status outputs.
    always_comb begin : control
        done_evt = (state_q == CAPTURE) && wr_en && (wr_idx == IW'(NBLK - 1));
        state_d  = state_q;
        case (state_q)
            IDLE:     if (cap_start)   state_d = WAIT_SOF;
            WAIT_SOF: if (start_frame) state_d = CAPTURE;
            CAPTURE:  if (done_evt)    state_d = DONE;
            DONE:     if (cap_start)   state_d = WAIT_SOF;
            default:                   state_d = IDLE;
        endcase
        busy_d        = (state_d == WAIT_SOF) || (state_d == CAPTURE);
        frame_ready_d = (state_d == DONE);
        frame_count_d = frame_count_q + 8'(done_evt);
        img_data_d    = (img_idx < IW'(NBLK)) ? mem[img_idx] : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin : regs
        if (!rstn) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            for (int i = 0; i < int'(OUT_DIM); i++) begin
                acc_q[i] <= '0;
            end
            s1_valid_q    <= 1'b0;
            s1_luma_q     <= '0;
            s1_bx_q       <= '0;
            s1_by_q       <= '0;
            s1_last_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_count_q <= '0;
            img_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            for (int i = 0; i < int'(OUT_DIM); i++) begin
                acc_q[i] <= acc_d[i];
            end
            s1_valid_q    <= s1_valid_d;
            s1_luma_q     <= s1_luma_d;
            s1_bx_q       <= s1_bx_d;
            s1_by_q       <= s1_by_d;
            s1_last_q     <= s1_last_d;
            busy_q        <= busy_d;
            frame_ready_q <= frame_ready_d;
            frame_count_q <= frame_count_d;
            img_data_q    <= img_data_d;
        end
    end

    // Image buffer storage; contents are not reset.
    always_ff @(posedge clk) begin : buffer_write
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign busy        = busy_q;
    assign frame_ready = frame_ready_q;
    assign frame_count = frame_count_q;
    assign img_data    = img_data_q;

endmodule

// File: tb/tb_mnist_frame_downsampler.sv
// Testbench for mnist_frame_downsampler, using a reduced frame geometry
// (2x2 blocks, 64x62 frame) so complete captures stay short.
module tb_mnist_frame_downsampler;

    localparam int H     = 64;
    localparam int V     = 62;
    localparam int X0    = 4;
    localparam int Y0    = 3;
    localparam int BL    = 1;
    localparam int OD    = 28;
    localparam int INV   = 1;
    localparam int BE    = 1 << BL;
    localparam int EDGE  = OD * BE;
    localparam int NPIX  = OD * OD;
    localparam int LASTX = X0 + EDGE - 1;
    localparam int LASTY = Y0 + EDGE - 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        cap_start;
    logic        busy;
    logic        frame_ready;
    logic [7:0]  frame_count;
    logic [9:0]  img_idx;
    logic [7:0]  img_data;

    logic [15:0] frame [V][H];
    int          expb [NPIX];
    logic [7:0]  got [NPIX];
    int          checks = 0;
    int          passes = 0;
    int          since = 0;
    int          ready_lat = -1;
    int          exp_count = 0;

    mnist_frame_downsampler #(
        .H_ACTIVE(H), .V_ACTIVE(V), .CROP_X0(X0), .CROP_Y0(Y0),
        .BLK_LOG2(BL), .OUT_DIM(OD), .INVERT(INV)
    ) dut (
        .clk(clk), .rstn(rstn), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_sof(pix_sof), .cap_start(cap_start), .busy(busy),
        .frame_ready(frame_ready), .frame_count(frame_count),
        .img_idx(img_idx), .img_data(img_data)
    );

    always #5 clk = ~clk;

    // Reference luma of one RGB565 pixel.
    function automatic int luma(input logic [15:0] p);
        int r, g, b, yv;
        r  = int'({p[15:11], p[15:13]});
        g  = int'({p[10:5],  p[10:9]});
        b  = int'({p[4:0],   p[4:2]});
        yv = (77 * r + 150 * g + 29 * b) / 256;
        if (INV != 0) yv = 255 - yv;
        return yv;
    endfunction

    // Expected buffer: mean luma of every block of the crop window.
    task automatic build_expected();
        for (int by = 0; by < OD; by++) begin
            for (int bx = 0; bx < OD; bx++) begin
                int s;
                s = 0;
                for (int j = 0; j < BE; j++)
                    for (int i = 0; i < BE; i++)
                        s += luma(frame[Y0 + by * BE + j][X0 + bx * BE + i]);
                expb[by * OD + bx] = s / (BE * BE);
            end
        end
    endtask

    task automatic fill(input int kind);
        logic [15:0] p;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                case (kind)
                    0: p = 16'hFFFF;
                    1: p = 16'h0000;
                    2: p = 16'hF800;
                    4: p = (x >= X0 && x < X0 + BE && y >= Y0 && y < Y0 + BE) ? 16'h0000 : 16'hFFFF;
                    5: p = (x > LASTX - BE && x <= LASTX && y > LASTY - BE && y <= LASTY &&
                            ((x + y) % 2 == 0)) ? 16'h0000 : 16'hFFFF;
                    default: p = 16'($urandom);
                endcase
                frame[y][x] = p;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (since > 0) begin
            since++;
            if (frame_ready === 1'b1 && ready_lat < 0) ready_lat = since;
        end
    endtask

    task automatic pulse_cap();
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
    endtask

    // Stream the frame array with random idle gaps; optionally stop early or
    // raise cap_start alongside pixel number cap_at.
    task automatic drive_frame(input int n_stop, input int cap_at, input int gap);
        int n;
        n = 0;
        since = 0;
        ready_lat = -1;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (n == n_stop) begin
                    pix_valid = 1'b0;
                    pix_sof   = 1'b0;
                    return;
                end
                while ($urandom_range(99) < gap) begin
                    pix_valid = 1'b0;
                    pix_sof   = 1'($urandom_range(1));
                    pix_data  = 16'($urandom);
                    tick();
                end
                pix_valid = 1'b1;
                pix_data  = frame[y][x];
                pix_sof   = (x == 0 && y == 0);
                cap_start = (n == cap_at);
                tick();
                cap_start = 1'b0;
                if (x == LASTX && y == LASTY) begin
                    since = 1;
                    if (frame_ready === 1'b1) ready_lat = 1;
                end
                n++;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        tick();
        tick();
    endtask

    task automatic read_buffer();
        for (int i = 0; i < NPIX; i++) begin
            img_idx = 10'(i);
            tick();
            got[i] = img_data;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0;
        cap_start = 1'b0; img_idx = '0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || frame_ready !== 1'b0 || frame_count !== 8'h00 || img_data !== 8'h00)
            $display("FAIL reset_outputs got busy=%b ready=%b count=%0d data=%h exp 0/0/0/00",
                     busy, frame_ready, frame_count, img_data);
        else passes++;
        img_idx = 10'd900;
        rstn = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || frame_ready !== 1'b0 || frame_count !== 8'h00)
            $display("FAIL reset_idle got busy=%b ready=%b count=%0d exp 0/0/0",
                     busy, frame_ready, frame_count);
        else passes++;
    endtask

    task automatic test_capture_frame(input int kind, input string name);
        fill(kind);
        build_expected();
        pulse_cap();
        checks++;
        if (busy !== 1'b1 || frame_ready !== 1'b0)
            $display("FAIL %s_armed got busy=%b ready=%b exp 1/0", name, busy, frame_ready);
        else passes++;
        drive_frame(-1, -1, 3);
        exp_count = (exp_count + 1) % 256;
        checks++;
        if (ready_lat !== 2)
            $display("FAIL %s_ready_latency got=%0d exp=2", name, ready_lat);
        else passes++;
        checks++;
        if (frame_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 8'(exp_count))
            $display("FAIL %s_status got ready=%b busy=%b count=%0d exp 1/0/%0d",
                     name, frame_ready, busy, frame_count, exp_count);
        else passes++;
        read_buffer();
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (got[i] !== 8'(expb[i]))
                $display("FAIL %s_buf idx=%0d got=%h exp=%h", name, i, got[i], 8'(expb[i]));
            else passes++;
        end
        if (kind == 2) begin
            checks++;
            if (got[0] !== 8'hB3) $display("FAIL red_const got=%h exp=b3", got[0]);
            else passes++;
        end
        if (kind == 5) begin
            checks++;
            if (got[NPIX-1] !== 8'h7F || got[NPIX-2] !== 8'h00)
                $display("FAIL half_block got783=%h got782=%h exp 7f/00", got[NPIX-1], got[NPIX-2]);
            else passes++;
        end
    endtask

    task automatic test_sof_restart();
        fill(3);
        pulse_cap();
        pulse_cap();
        checks++;
        if (busy !== 1'b1 || frame_ready !== 1'b0 || frame_count !== 8'(exp_count))
            $display("FAIL restart_armed got busy=%b ready=%b count=%0d exp 1/0/%0d",
                     busy, frame_ready, frame_count, exp_count);
        else passes++;
        drive_frame(1500, -1, 3);
        checks++;
        if (busy !== 1'b1 || frame_ready !== 1'b0 || frame_count !== 8'(exp_count))
            $display("FAIL restart_partial got busy=%b ready=%b count=%0d exp 1/0/%0d",
                     busy, frame_ready, frame_count, exp_count);
        else passes++;
        fill(3);
        build_expected();
        drive_frame(-1, -1, 3);
        exp_count = (exp_count + 1) % 256;
        checks++;
        if (ready_lat !== 2 || frame_count !== 8'(exp_count))
            $display("FAIL restart_done got lat=%0d count=%0d exp 2/%0d", ready_lat, frame_count, exp_count);
        else passes++;
        read_buffer();
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (got[i] !== 8'(expb[i]))
                $display("FAIL restart_buf idx=%0d got=%h exp=%h", i, got[i], 8'(expb[i]));
            else passes++;
        end
    endtask

    task automatic test_cap_ignored();
        fill(3);
        build_expected();
        pulse_cap();
        drive_frame(-1, 2000, 3);
        exp_count = (exp_count + 1) % 256;
        checks++;
        if (ready_lat !== 2 || frame_count !== 8'(exp_count) || busy !== 1'b0)
            $display("FAIL capign_done got lat=%0d count=%0d busy=%b exp 2/%0d/0",
                     ready_lat, frame_count, busy, exp_count);
        else passes++;
        read_buffer();
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (got[i] !== 8'(expb[i]))
                $display("FAIL capign_buf idx=%0d got=%h exp=%h", i, got[i], 8'(expb[i]));
            else passes++;
        end
    endtask

    task automatic test_oob_read();
        img_idx = 10'd900;
        tick();
        checks++;
        if (img_data !== 8'h00) $display("FAIL oob_900 got=%h exp=00", img_data);
        else passes++;
        img_idx = 10'd784;
        tick();
        checks++;
        if (img_data !== 8'h00) $display("FAIL oob_784 got=%h exp=00", img_data);
        else passes++;
        img_idx = 10'd783;
        tick();
        checks++;
        if (img_data !== 8'(expb[NPIX-1])) $display("FAIL read_783 got=%h exp=%h", img_data, 8'(expb[NPIX-1]));
        else passes++;
    endtask

    task automatic test_rstn_abort();
        fill(0);
        pulse_cap();
        drive_frame(2500, -1, 0);
        img_idx = 10'd5;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || frame_ready !== 1'b0 || frame_count !== 8'h00 || img_data !== 8'h00)
            $display("FAIL abort_async got busy=%b ready=%b count=%0d data=%h exp 0/0/0/00",
                     busy, frame_ready, frame_count, img_data);
        else passes++;
        tick(); tick();
        rstn = 1'b1;
        exp_count = 0;
        tick();
        checks++;
        if (busy !== 1'b0 || frame_count !== 8'h00)
            $display("FAIL abort_idle got busy=%b count=%0d exp 0/0", busy, frame_count);
        else passes++;
        test_capture_frame(1, "after_abort");
    endtask

    initial begin
        test_reset();
        test_capture_frame(0, "white");
        test_capture_frame(1, "black");
        test_capture_frame(2, "red");
        test_capture_frame(4, "blk0");
        test_capture_frame(5, "blk783");
        test_capture_frame(3, "random");
        test_sof_restart();
        test_cap_ignored();
        test_oob_read();
        test_rstn_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
